// File: rtl/div_seq_n.sv
// Sequential restoring divider, one quotient bit per clock, unsigned or signed.
// Go/done handshake with divide-by-zero and signed-overflow detection.
module div_seq_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       CS
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StCalc = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] xa_q, ya_q;
  logic             smode_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNTW-1:0]  cnt_q;
  logic             sign_q_q, sign_r_q;

  logic             sx, sy;
  logic [WIDTH-1:0] xa_mag, ya_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    sx      = smode_q & xa_q[WIDTH-1];
    sy      = smode_q & ya_q[WIDTH-1];
    xa_mag  = sx ? -xa_q : xa_q;
    ya_mag  = sy ? -ya_q : ya_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    // The restored remainder is always below |y|, so it fits back into WIDTH bits.
    rem_next = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      xa_q     <= '0;
      ya_q     <= '0;
      smode_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      q        <= '0;
      r        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            xa_q    <= x;
            ya_q    <= y;
            smode_q <= signed_mode;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (ya_q == '0) begin
            q       <= '1;
            r       <= xa_q;
            state_q <= StErr;
          end else if (smode_q && xa_q == MinVal && ya_q == '1) begin
            q       <= MinVal;
            r       <= '0;
            state_q <= StErr;
          end else begin
            quo_q    <= xa_mag;
            dvs_q    <= ya_mag;
            rem_q    <= '0;
            cnt_q    <= CNTW'(WIDTH);
            sign_q_q <= sx ^ sy;
            sign_r_q <= sx;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], ge};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) state_q <= StFix;
        end
        StFix: begin
          q       <= sign_q_q ? -quo_q : quo_q;
          r       <= sign_r_q ? -rem_q : rem_q;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy  = state_q != StIdle;
    done  = (state_q == StDone) || (state_q == StErr);
    error = state_q == StErr;
    CS    = state_q;
  end

endmodule

// File: tb/tb_div_seq_n.sv
// Self-checking bench for div_seq_n: directed and random operations at WIDTH 8,
// plus directed/random runs on WIDTH 4 and WIDTH 16 instances.
module tb_div_seq_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8 instance
  logic       go, sm;
  logic [7:0] x, y, q, r;
  logic       busy, done, error;
  logic [2:0] cs;

  div_seq_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .go(go), .signed_mode(sm), .x(x), .y(y),
    .q(q), .r(r), .busy(busy), .done(done), .error(error), .CS(cs)
  );

  // WIDTH = 4 instance
  logic       go4, sm4, busy4, done4, error4;
  logic [3:0] x4, y4, q4, r4;
  logic [2:0] cs4;

  div_seq_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .go(go4), .signed_mode(sm4), .x(x4), .y(y4),
    .q(q4), .r(r4), .busy(busy4), .done(done4), .error(error4), .CS(cs4)
  );

  // WIDTH = 16 instance
  logic        go16, sm16, busy16, done16, error16;
  logic [15:0] x16, y16, q16, r16;
  logic [2:0]  cs16;

  div_seq_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16), .signed_mode(sm16), .x(x16), .y(y16),
    .q(q16), .r(r16), .busy(busy16), .done(done16), .error(error16), .CS(cs16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV int '/' truncates toward zero, '%' follows dividend.
  task automatic model8(input logic m, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] eq, output logic [7:0] er, output logic ee);
    int ia, ib;
    ee = 1'b0;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; ee = 1'b1;
    end else if (m && a == 8'h80 && b == 8'hFF) begin
      eq = 8'h80; er = 8'h00; ee = 1'b1;
    end else if (m) begin
      ia = $signed(a);
      ib = $signed(b);
      eq = 8'(ia / ib);
      er = 8'(ia % ib);
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b,
                      input bit disturb);
    logic [7:0] eq, er;
    logic       ee;
    int         k, exp_k;
    bit         busy_ok;
    model8(m, a, b, eq, er, ee);
    exp_k = ee ? 1 : 10;
    @(negedge clk);
    go = 1'b1; sm = m; x = a; y = b;
    @(posedge clk); #1;
    check("cs_load", {29'd0, cs}, 32'd1);
    busy_ok = 1'b1;
    k = 0;
    while (k < 40 && !done) begin
      @(negedge clk);
      if (disturb) begin
        go = 1'($urandom); x = 8'($urandom); y = 8'($urandom); sm = 1'($urandom);
      end else begin
        go = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (!busy) busy_ok = 1'b0;
    end
    check("done_edge", k, exp_k);
    check("q", {24'd0, q}, {24'd0, eq});
    check("r", {24'd0, r}, {24'd0, er});
    check("error", {31'd0, error}, {31'd0, ee});
    check("cs_end", {29'd0, cs}, ee ? 32'd5 : 32'd4);
    check("busy_run", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk); #1;
    check("cs_idle", {29'd0, cs}, 32'd0);
    check("done_low", {31'd0, done}, 32'd0);
    check("q_hold", {24'd0, q}, {24'd0, eq});
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    int k;
    @(negedge clk);
    go16 = 1'b1; x16 = a; y16 = b;
    @(posedge clk);
    @(negedge clk);
    go16 = 1'b0;
    k = 0;
    while (k < 60 && !done16) begin
      @(posedge clk); #1;
      k++;
    end
    check("w16_done_edge", k, 32'd18);
    check("w16_q", {16'd0, q16}, {16'd0, a / b});
    check("w16_r", {16'd0, r16}, {16'd0, a % b});
    check("w16_error", {31'd0, error16}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] a, b;
    logic       m;
    int         k, k2, sel;
    bit         seen;

    go = 0; sm = 0; x = 0; y = 0;
    go4 = 0; sm4 = 0; x4 = 0; y4 = 0;
    go16 = 0; sm16 = 0; x16 = 0; y16 = 0;

    #1;
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_r", {24'd0, r}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_cs", {29'd0, cs}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run8(1'b0, 8'd200, 8'd7, 1'b0);
    run8(1'b1, 8'h9C, 8'd7, 1'b0);
    run8(1'b1, 8'd100, 8'hF9, 1'b0);
    run8(1'b0, 8'h55, 8'h00, 1'b0);
    run8(1'b1, 8'h55, 8'h00, 1'b0);
    run8(1'b1, 8'h80, 8'hFF, 1'b0);
    run8(1'b0, 8'h80, 8'hFF, 1'b0);
    run8(1'b1, 8'h80, 8'h01, 1'b0);
    run8(1'b0, 8'd200, 8'd7, 1'b1);

    for (int i = 0; i < 40; i++) begin
      m   = 1'($urandom);
      a   = 8'($urandom);
      sel = $urandom_range(0, 9);
      b   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      if (sel == 2) a = 8'h80;
      run8(m, a, b, (i % 4) == 3);
    end

    // go held high: a new operation starts on the edge after returning to IDLE.
    @(negedge clk);
    go = 1'b1; sm = 1'b0; x = 8'd200; y = 8'd7;
    k = 0;
    while (k < 40 && !done) begin
      @(posedge clk); #1;
      k++;
    end
    check("held_first_done", k, 32'd11);
    k2 = 0;
    do begin
      @(posedge clk); #1;
      k2++;
    end while (k2 < 40 && !done);
    check("held_period", k2, 32'd12);
    check("held_q", {24'd0, q}, 32'd28);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk); #1;
    check("held_idle", {29'd0, cs}, 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    go = 1'b1; x = 8'd200; y = 8'd7;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_q", {24'd0, q}, 32'd0);
    check("midrst_r", {24'd0, r}, 32'd0);
    check("midrst_cs", {29'd0, cs}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", {31'd0, seen}, 32'd0);
    check("midrst_cs_after", {29'd0, cs}, 32'd0);

    // WIDTH = 4: 13 / 3
    @(negedge clk);
    go4 = 1'b1; x4 = 4'd13; y4 = 4'd3;
    @(posedge clk);
    @(negedge clk);
    go4 = 1'b0;
    k = 0;
    while (k < 40 && !done4) begin
      @(posedge clk); #1;
      k++;
    end
    check("w4_done_edge", k, 32'd6);
    check("w4_q", {28'd0, q4}, 32'd4);
    check("w4_r", {28'd0, r4}, 32'd1);
    @(posedge clk); #1;

    run16(16'hFFFF, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      run16(16'($urandom), 16'($urandom_range(1, 16'hFFFF)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
